neopixel_bit_serializer: RTL and testbench

- Downstream stage of the NeopixelDriver AXI4-Lite register block.
- Takes GRB pixel words over a valid/ready stream and produces the single-wire WS2812 serial waveform.
- Handles per-bit high/low timing and inserts the end-of-frame latch (reset) period.
- Holds one pixel in a skid register, so consecutive pixels are sent with no inter-pixel gap.

---
 rtl/neopixel_bit_serializer.sv | 196 +++++++++++++++++++
 tb/tb_neopixel_bit_serializer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/neopixel_bit_serializer.sv
// neopixel_bit_serializer
//   Serializes GRB (or GRBW) pixel words into the single-wire WS2812 waveform.
//   A one-word skid register sits in front of the shift register. The next
//   pixel can be accepted while the current one is being sent, which gives
//   back-to-back pixels with no inter-pixel gap. A frame ends with a low
//   latch period of T_LATCH cycles.
//
//   Optional feature: define NEOPIXEL_RGBW_EN for 32-bit GRBW pixels (SK6812).
//   Without it, pixels are 24-bit GRB.
//
// Ports
//   ACLK           system clock, rising edge
//   ARESET         asynchronous active-high reset
//   enable         permits a new frame to start from IDLE
//   s_pixel_data   pixel word, MSB sent first
//   s_pixel_valid  pixel word offered
//   s_pixel_last   final pixel of the frame (qualified by valid)
//   s_pixel_ready  skid register can accept a word
//   dout           registered serial line
//   busy           FSM not idle, or skid register occupied
//   frame_done     one-cycle pulse when a latch period completes
//   underrun       sticky: a non-last pixel ran out with no successor
//   clr_underrun   synchronous clear of underrun (a coincident set wins)
//   state_dbg      current FSM state (0 IDLE, 1 BIT, 2 LATCH)
//
// Handshake: a word transfers on a rising edge where s_pixel_valid and
// s_pixel_ready are both high. Ready does not depend on valid. Ready stays
// low while the skid register is full, during LATCH, and during reset.
module neopixel_bit_serializer #(
  parameter int T_BIT   = 125,
  parameter int T0H     = 40,
  parameter int T1H     = 80,
  parameter int T_LATCH = 5000,
`ifdef NEOPIXEL_RGBW_EN
  localparam int PIX_W  = 32
`else
  localparam int PIX_W  = 24
`endif
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             enable,
  input  logic [PIX_W-1:0] s_pixel_data,
  input  logic             s_pixel_valid,
  input  logic             s_pixel_last,
  output logic             s_pixel_ready,
  output logic             dout,
  output logic             busy,
  output logic             frame_done,
  output logic             underrun,
  input  logic             clr_underrun,
  output logic [1:0]       state_dbg
);

  localparam int CNT_MAX = (T_LATCH > T_BIT) ? T_LATCH : T_BIT;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int IDX_W   = $clog2(PIX_W);

  localparam logic [CNT_W-1:0] T0H_C        = CNT_W'(T0H);
  localparam logic [CNT_W-1:0] T1H_C        = CNT_W'(T1H);
  localparam logic [CNT_W-1:0] T_BIT_LAST   = CNT_W'(T_BIT - 1);
  localparam logic [CNT_W-1:0] T_LATCH_LAST = CNT_W'(T_LATCH - 1);
  localparam logic [IDX_W-1:0] IDX_TOP      = IDX_W'(PIX_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BIT   = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [PIX_W-1:0]   shift_q, shift_n;
  logic               cur_last, cur_last_n;
  logic [IDX_W-1:0]   bit_idx, bit_idx_n;
  logic [PIX_W-1:0]   skid_data;
  logic               skid_last;
  logic               skid_full;
  logic               load_skid;
  logic               set_underrun;
  logic               done_n;
  logic               dout_n;
  logic               xfer;

  assign s_pixel_ready = !ARESET && !skid_full && (state != S_LATCH);
  assign xfer          = s_pixel_valid && s_pixel_ready;
  assign busy          = (state != S_IDLE) || skid_full;
  assign state_dbg     = state;

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    shift_n      = shift_q;
    cur_last_n   = cur_last;
    bit_idx_n    = bit_idx;
    load_skid    = 1'b0;
    set_underrun = 1'b0;
    done_n       = 1'b0;
    dout_n       = 1'b0;
    case (state)
      S_IDLE: begin
        if (skid_full && enable) begin
          load_skid = 1'b1;
          cnt_n     = '0;
          state_n   = S_BIT;
        end
      end
      S_BIT: begin
        // High phase length depends on the bit currently at the MSB.
        dout_n = (cnt < (shift_q[PIX_W-1] ? T1H_C : T0H_C));
        if (cnt == T_BIT_LAST) begin
          cnt_n   = '0;
          shift_n = {shift_q[PIX_W-2:0], 1'b0};
          if (bit_idx != '0) begin
            bit_idx_n = bit_idx - 1'b1;
          end else if (cur_last) begin
            state_n = S_LATCH;
          end else if (skid_full) begin
            // Seamless reload: next bit's high phase starts next cycle.
            load_skid = 1'b1;
          end else begin
            set_underrun = 1'b1;
            state_n      = S_LATCH;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_LATCH: begin
        if (cnt == T_LATCH_LAST) begin
          done_n  = 1'b1;
          cnt_n   = '0;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (load_skid) begin
      shift_n    = skid_data;
      cur_last_n = skid_last;
      bit_idx_n  = IDX_TOP;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state      <= S_IDLE;
      cnt        <= '0;
      shift_q    <= '0;
      cur_last   <= 1'b0;
      bit_idx    <= '0;
      dout       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      shift_q    <= shift_n;
      cur_last   <= cur_last_n;
      bit_idx    <= bit_idx_n;
      dout       <= dout_n;
      frame_done <= done_n;
    end
  end

  // Load and capture are exclusive: loading needs skid_full, capture needs
  // ready, which needs !skid_full.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      skid_data <= '0;
      skid_last <= 1'b0;
      skid_full <= 1'b0;
    end else begin
      if (load_skid) begin
        skid_full <= 1'b0;
      end
      if (xfer) begin
        skid_data <= s_pixel_data;
        skid_last <= s_pixel_last;
        skid_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      underrun <= 1'b0;
    end else if (set_underrun) begin
      underrun <= 1'b1;
    end else if (clr_underrun) begin
      underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_neopixel_bit_serializer.sv
// Self-checking bench for neopixel_bit_serializer.
// Expected high times per bit are queued when a pixel is handed over. They
// are popped as the serial line produces each high pulse.
module tb_neopixel_bit_serializer;

`ifdef NEOPIXEL_RGBW_EN
  localparam int PIX_W = 32;
`else
  localparam int PIX_W = 24;
`endif
  localparam int T_BIT   = 125;
  localparam int T0H     = 40;
  localparam int T1H     = 80;
  localparam int T_LATCH = 5000;
  localparam int B       = PIX_W * T_BIT;   // cycles of bits per pixel

  // clock / reset
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic [PIX_W-1:0] s_pixel_data = '0;
  logic             s_pixel_valid = 1'b0;
  logic             s_pixel_last = 1'b0;
  logic             s_pixel_ready;
  logic             dout;
  logic             busy;
  logic             frame_done;
  logic             underrun;
  logic             clr_underrun = 1'b0;
  logic [1:0]       state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  neopixel_bit_serializer dut (
    .ACLK          (clk),
    .ARESET        (rst),
    .enable        (enable),
    .s_pixel_data  (s_pixel_data),
    .s_pixel_valid (s_pixel_valid),
    .s_pixel_last  (s_pixel_last),
    .s_pixel_ready (s_pixel_ready),
    .dout          (dout),
    .busy          (busy),
    .frame_done    (frame_done),
    .underrun      (underrun),
    .clr_underrun  (clr_underrun),
    .state_dbg     (state_dbg)
  );

  // scoreboard
  logic [15:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // monitor: measures high-pulse widths and rise-to-rise bit periods
  int   high_len   = 0;
  int   since_rise = 0;
  bit   seen_rise  = 1'b0;
  logic prev_dout  = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      high_len   = 0;
      since_rise = 0;
      seen_rise  = 1'b0;
      prev_dout  = 1'b0;
    end else begin
      if (dout) begin
        if (!prev_dout) begin
          if (seen_rise && since_rise < 1000) check("bit_period", since_rise, T_BIT);
          since_rise = 0;
          seen_rise  = 1'b1;
        end
        high_len++;
      end else if (prev_dout) begin
        if (exp_q.size() == 0) check("unexpected_pulse", high_len, 0);
        else                   check("high_time", high_len, exp_q.pop_front());
        high_len = 0;
      end
      since_rise++;
      prev_dout = dout;
    end
  end

  // driver tasks
  task automatic send_pixel(input logic [PIX_W-1:0] d, input logic l, output int hs);
    int n = 0;
    s_pixel_data  = d;
    s_pixel_last  = l;
    s_pixel_valid = 1'b1;
    while (!s_pixel_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!s_pixel_ready) check("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    hs = cyc;
    s_pixel_valid = 1'b0;
    for (int i = PIX_W - 1; i >= 0; i--) exp_q.push_back(d[i] ? 16'(T1H) : 16'(T0H));
  endtask

  task automatic wait_rise(output int rc);
    int n = 0;
    while (!dout && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!dout) check("rise_timeout", 0, 1);
    rc = cyc;
  endtask

  task automatic wait_done(output int dc);
    int n = 0;
    while (!frame_done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!frame_done) check("done_timeout", 0, 1);
    dc = cyc;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=%0d exp=0", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hs1, hs2, r1, dc, k;
    logic [PIX_W-1:0] p;

    // reset state
    wait_cycles(3);
    check("rst_dout", dout, 0);
    check("rst_ready", s_pixel_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_underrun", underrun, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", s_pixel_ready, 1);
    enable = 1'b1;

    // single pixel, last
`ifdef NEOPIXEL_RGBW_EN
    p = 32'h000000FF;
`else
    p = 24'hAA5500;
`endif
    send_pixel(p, 1'b1, hs1);
    check("single_accept_ready", s_pixel_ready, 0);
    wait_rise(r1);
    check("single_latency", r1 - hs1, 2);
    wait_done(dc);
    // Bit phase starts one cycle before dout's first rise; the done pulse
    // is registered at the end of the latch.
    check("single_frame_len", dc - r1, B + T_LATCH - 1);
    check("single_dout_at_done", dout, 0);
    check("single_busy_at_done", busy, 0);
    @(negedge clk);
    check("single_done_once", frame_done, 0);
    check("single_highs_used", exp_q.size(), 0);
    check("single_no_underrun", underrun, 0);

    // two pixels back to back
    send_pixel('1, 1'b0, hs1);
    send_pixel('0, 1'b1, hs2);
    check("pair_skid_full_ready", s_pixel_ready, 0);
    wait_rise(r1);
    check("pair_latency", r1 - hs1, 2);
    check("pair_p2_during_p1", (hs2 < r1 + B) ? 1 : 0, 1);
    wait_done(dc);
    check("pair_frame_len", dc - r1, 2 * B + T_LATCH - 1);
    check("pair_highs_used", exp_q.size(), 0);
    check("pair_no_underrun", underrun, 0);
    @(negedge clk);

    // underrun: a non-last pixel with no successor
    send_pixel(PIX_W'(24'h123456), 1'b0, hs1);
    wait_rise(r1);
    wait_until(r1 + B - 2);
    check("underrun_not_early", underrun, 0);
    @(negedge clk);
    check("underrun_set", underrun, 1);
    check("underrun_state_latch", state_dbg, 2);
    check("underrun_ready_in_latch", s_pixel_ready, 0);
    wait_done(dc);
    check("underrun_frame_len", dc - r1, B + T_LATCH - 1);
    check("underrun_sticky", underrun, 1);
    clr_underrun = 1'b1;
    @(negedge clk);
    clr_underrun = 1'b0;
    check("underrun_cleared", underrun, 0);
    check("underrun_highs_used", exp_q.size(), 0);

    // enable low holds an accepted pixel
    enable = 1'b0;
    send_pixel('1, 1'b1, hs1);
    wait_cycles(50);
    check("en_low_ready", s_pixel_ready, 0);
    check("en_low_dout", dout, 0);
    check("en_low_busy", busy, 1);
    check("en_low_state", state_dbg, 0);
    enable = 1'b1;
    k = cyc;
    wait_rise(r1);
    // The next edge starts the frame; dout is registered one edge later.
    check("en_rise_delay", r1 - k, 2);
    wait_done(dc);
    check("en_frame_len", dc - r1, B + T_LATCH - 1);
    check("en_highs_used", exp_q.size(), 0);
    @(negedge clk);

    // asynchronous reset in the high phase of a 1 bit
    send_pixel('1, 1'b1, hs1);
    wait_rise(r1);
    wait_until(r1 + 20);
    check("arst_pre_dout", dout, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_dout", dout, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", s_pixel_ready, 0);
    exp_q.delete();
    wait_cycles(3);
    rst = 1'b0;
    @(negedge clk);
    check("arst_release_ready", s_pixel_ready, 1);
    wait_cycles(300);
    check("arst_idle_dout", dout, 0);
    check("arst_idle_busy", busy, 0);
    check("arst_idle_done", frame_done, 0);

    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
